// File: rtl/risc_io_bridge.sv
`default_nettype none
// ============================================================================
// Module   : risc_io_bridge
// Purpose  : Bridges a stalling core IO port to NUM_CH request/ack channels.
//            Optional macro IO_TIMEOUT_EN adds a bounded WAIT with error.
// Revision : 1.0 - initial release
// ============================================================================
module risc_io_bridge #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int NUM_CH      = 4,
  parameter int CH_SEL_LSB  = 12,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ADDR_W-1:0]        io_address,
  input  logic [DATA_W-1:0]        io_write_value,
  input  logic                     io_write_en,
  input  logic                     io_read_en,
  output logic [DATA_W-1:0]        io_read_value,
  output logic                     io_stall,
  output logic [ADDR_W-1:0]        ch_addr,
  output logic [DATA_W-1:0]        ch_wdata,
  output logic                     ch_we,
  output logic [NUM_CH-1:0]        ch_req,
  input  logic [NUM_CH-1:0]        ch_ack,
  input  logic [NUM_CH*DATA_W-1:0] ch_rdata,
  output logic                     bus_err
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CH_W:0] C_NUM_CH = (CH_W+1)'(NUM_CH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                we_q, we_d;
  logic [NUM_CH-1:0]   req_q, req_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                bus_err_q, bus_err_d;

  logic                access;
  logic                illegal;
  logic [CH_W-1:0]     sel;
  logic                mapped;
  logic [NUM_CH-1:0]   sel_onehot;
  logic                ack_hit;
  logic [DATA_W-1:0]   sel_rdata;
  logic                tmo_expire;

  assign access  = io_read_en ^ io_write_en;
  assign illegal = io_read_en & io_write_en;
  assign sel     = io_address[CH_SEL_LSB +: CH_W];
  assign mapped  = ({1'b0, sel} < C_NUM_CH);

  // The registered one-hot request doubles as the selected-channel mask,
  // so acks and read data from other channels are naturally ignored.
  assign ack_hit = |(ch_ack & req_q);

  always_comb begin
    sel_onehot = '0;
    sel_rdata  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sel_onehot[i] = (sel == CH_W'(i));
      sel_rdata     = sel_rdata | ({DATA_W{req_q[i]}} & ch_rdata[i*DATA_W +: DATA_W]);
    end
  end

`ifdef IO_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  assign tmo_expire = (state_q == ST_WAIT) && !ack_hit &&
                      (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1));

  // Held at zero outside WAIT, so every WAIT entry starts from a clean count.
  always_comb begin
    tmo_cnt_d = '0;
    if (state_q == ST_WAIT) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYC;
  assign tmo_expire = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    we_d          = we_q;
    req_d         = req_q;
    rdata_d       = rdata_q;
    bus_err_d     = 1'b0;
    io_stall      = 1'b0;
    io_read_value = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (access && mapped) begin
          io_stall = 1'b1;
          state_d  = ST_WAIT;
          addr_d   = io_address;
          wdata_d  = io_write_value;
          we_d     = io_write_en;
          req_d    = sel_onehot;
        end else if (access || illegal) begin
          bus_err_d = 1'b1;
        end
      end
      ST_WAIT: begin
        io_stall = 1'b1;
        // An ack on the expiry edge wins over the timeout.
        if (ack_hit) begin
          req_d   = '0;
          state_d = ST_DONE;
          if (!we_q) begin
            rdata_d = sel_rdata;
          end
        end else if (tmo_expire) begin
          req_d     = '0;
          rdata_d   = '1;
          bus_err_d = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        io_read_value = rdata_q;
        state_d       = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      req_q     <= '0;
      rdata_q   <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      req_q     <= req_d;
      rdata_q   <= rdata_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign ch_addr  = addr_q;
  assign ch_wdata = wdata_q;
  assign ch_we    = we_q;
  assign ch_req   = req_q;
  assign bus_err  = bus_err_q;

endmodule
`default_nettype wire

// File: tb/tb_risc_io_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_risc_io_bridge
// Purpose  : Scoreboard bench for risc_io_bridge (4-channel and 3-channel).
// Revision : 1.0 - initial release
// ============================================================================
module tb_risc_io_bridge;

  localparam int DW = 32;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Main instance, four channels
  logic [AW-1:0]   io_address;
  logic [DW-1:0]   io_write_value;
  logic            io_write_en;
  logic            io_read_en;
  logic [DW-1:0]   io_read_value;
  logic            io_stall;
  logic [AW-1:0]   ch_addr;
  logic [DW-1:0]   ch_wdata;
  logic            ch_we;
  logic [3:0]      ch_req;
  logic [3:0]      ch_ack;
  logic [4*DW-1:0] ch_rdata;
  logic            bus_err;

  // Second instance, three channels, for the unmapped selector
  logic [AW-1:0]   io_address3;
  logic            io_read_en3;
  logic [DW-1:0]   io_read_value3;
  logic            io_stall3;
  logic [AW-1:0]   ch_addr3;
  logic [DW-1:0]   ch_wdata3;
  logic            ch_we3;
  logic [2:0]      ch_req3;
  logic            bus_err3;

  int n_checks = 0;
  int n_errors = 0;
  logic [32:0] sb_q[$];
  logic [32:0] mon_e;
  logic        prev_stall;

  risc_io_bridge #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_CH(4), .CH_SEL_LSB(12), .TIMEOUT_CYC(16)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .io_address(io_address), .io_write_value(io_write_value),
    .io_write_en(io_write_en), .io_read_en(io_read_en),
    .io_read_value(io_read_value), .io_stall(io_stall),
    .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_we(ch_we),
    .ch_req(ch_req), .ch_ack(ch_ack), .ch_rdata(ch_rdata),
    .bus_err(bus_err)
  );

  risc_io_bridge #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_CH(3), .CH_SEL_LSB(12), .TIMEOUT_CYC(16)
  ) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .io_address(io_address3), .io_write_value('0),
    .io_write_en(1'b0), .io_read_en(io_read_en3),
    .io_read_value(io_read_value3), .io_stall(io_stall3),
    .ch_addr(ch_addr3), .ch_wdata(ch_wdata3), .ch_we(ch_we3),
    .ch_req(ch_req3), .ch_ack(3'b000), .ch_rdata('0),
    .bus_err(bus_err3)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Completion monitor: a falling stall outside reset marks the DONE cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall && !io_stall) begin
        if (sb_q.size() == 0) begin
          check("sb_underflow", 64'd1, 64'd0);
        end else begin
          mon_e = sb_q.pop_front();
          if (mon_e[32]) check("done_rdata", io_read_value, mon_e[31:0]);
        end
      end
      prev_stall <= io_stall;
    end
  end

  // nw = number of WAIT cycles; the ack is raised during the last one.
  task automatic do_access(input logic [31:0] addr, input logic [31:0] wdata,
                           input logic wr, input int nw,
                           input logic [31:0] rdata, input logic noise);
    int   ch;
    int   stall_cnt;
    int   req_cnt;
    logic hold_bad;
    ch        = int'(addr[13:12]);
    stall_cnt = 0;
    req_cnt   = 0;
    hold_bad  = 1'b0;
    ch_rdata[ch*DW +: DW] = rdata;
    sb_q.push_back({~wr, rdata});
    io_address     = addr;
    io_write_value = wdata;
    io_write_en    = wr;
    io_read_en     = ~wr;
    @(negedge clk);
    if (io_stall) stall_cnt++;
    check("idle_req", ch_req, 64'd0);
    for (int k = 1; k <= nw; k++) begin
      @(posedge clk); #1;
      ch_ack = '0;
      if (k == nw) ch_ack[ch] = 1'b1;
      else if (noise) ch_ack[3] = 1'b1;
      @(negedge clk);
      if (io_stall) stall_cnt++;
      if (ch_req === (4'b0001 << ch)) req_cnt++;
      else hold_bad = 1'b1;
      if (ch_addr !== addr || ch_we !== wr || io_read_value !== '0 ||
          (wr && ch_wdata !== wdata) || bus_err !== 1'b0)
        hold_bad = 1'b1;
    end
    @(posedge clk); #1;
    ch_ack      = '0;
    io_read_en  = 1'b0;
    io_write_en = 1'b0;
    @(negedge clk);
    check("wait_hold", hold_bad, 64'd0);
    check("req_cycles", req_cnt, nw);
    check("stall_cycles", stall_cnt, nw + 1);
    check("done_req", ch_req, 64'd0);
    check("done_stall", io_stall, 64'd0);
    check("done_bus_err", bus_err, 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    io_address     = '0;
    io_write_value = '0;
    io_write_en    = 1'b0;
    io_read_en     = 1'b0;
    ch_ack         = '0;
    ch_rdata       = '0;
    io_address3    = '0;
    io_read_en3    = 1'b0;
    rst_n          = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_req", ch_req, 64'd0);
    check("rst_stall", io_stall, 64'd0);
    check("rst_bus_err", bus_err, 64'd0);
    check("rst_we", ch_we, 64'd0);
    check("rst_addr", ch_addr, 64'd0);
    check("rst_wdata", ch_wdata, 64'd0);
    check("rst_rdata", io_read_value, 64'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Read ch2, ack in first WAIT cycle
    do_access(32'h0000_2010, 32'h0, 1'b0, 1, 32'hDEAD_BEEF, 1'b0);
    // Write ch1, ack in fifth WAIT cycle
    do_access(32'h0000_1004, 32'h1234_5678, 1'b1, 5, 32'h0, 1'b0);
    // Read ch3 with a couple of extra wait cycles
    do_access(32'h0000_3008, 32'h0, 1'b0, 3, 32'hCAFE_F00D, 1'b0);
    // Read ch0 while ch3 acks repeatedly: only the ch0 ack completes
    do_access(32'h0000_0000, 32'h0, 1'b0, 4, 32'h0BAD_C0DE, 1'b1);

    // Both strobes high: illegal, no stall, error pulse next cycle
    io_address  = 32'h0000_2000;
    io_read_en  = 1'b1;
    io_write_en = 1'b1;
    @(negedge clk);
    check("illegal_stall", io_stall, 64'd0);
    check("illegal_rdata", io_read_value, 64'd0);
    @(posedge clk); #1;
    io_read_en  = 1'b0;
    io_write_en = 1'b0;
    @(negedge clk);
    check("illegal_bus_err", bus_err, 64'd1);
    check("illegal_req", ch_req, 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("illegal_bus_err_end", bus_err, 64'd0);
    @(posedge clk); #1;

    // Three-channel instance: selector 3 is unmapped
    io_address3 = 32'h0000_3000;
    io_read_en3 = 1'b1;
    @(negedge clk);
    check("unmap_stall", io_stall3, 64'd0);
    check("unmap_rdata", io_read_value3, 64'd0);
    check("unmap_bus_err_early", bus_err3, 64'd0);
    @(posedge clk); #1;
    io_read_en3 = 1'b0;
    @(negedge clk);
    check("unmap_bus_err", bus_err3, 64'd1);
    check("unmap_req", ch_req3, 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("unmap_bus_err_end", bus_err3, 64'd0);
    @(posedge clk); #1;

`ifdef IO_TIMEOUT_EN
    begin
      int cnt;
      cnt = 0;
      io_address = 32'h0000_0000;
      io_read_en = 1'b1;
      sb_q.push_back({1'b1, 32'hFFFF_FFFF});
      @(negedge clk);
      @(posedge clk); #1;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (ch_req[0]) cnt++;
        else break;
      end
      io_read_en = 1'b0;
      check("tmo_req_cycles", cnt, 64'd16);
      check("tmo_bus_err", bus_err, 64'd1);
      @(posedge clk); #1;
      @(negedge clk);
      check("tmo_bus_err_end", bus_err, 64'd0);
      @(posedge clk); #1;
    end
`else
    // Without the timeout option a long WAIT simply persists until ack
    do_access(32'h0000_0000, 32'h0, 1'b0, 20, 32'h1357_9BDF, 1'b0);
`endif

    // Reset during the third WAIT cycle of a ch1 read
    io_address = 32'h0000_1000;
    io_read_en = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_req", ch_req, 64'd2);
    rst_n      = 1'b0;
    io_read_en = 1'b0;
    #1;
    check("mid_rst_req", ch_req, 64'd0);
    check("mid_rst_stall", io_stall, 64'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    ch_ack[1] = 1'b1;
    @(posedge clk); #1;
    ch_ack = '0;
    @(negedge clk);
    check("late_ack_req", ch_req, 64'd0);
    check("late_ack_stall", io_stall, 64'd0);
    check("late_ack_bus_err", bus_err, 64'd0);
    check("late_ack_rdata", io_read_value, 64'd0);
    @(posedge clk); #1;
    do_access(32'h0000_1000, 32'h0, 1'b0, 2, 32'h55AA_1234, 1'b0);

    repeat (2) @(posedge clk);
    check("sb_empty", sb_q.size(), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/risc_io_bridge.md
RISC_IO_BRIDGE -- requirements
Module: risc_io_bridge

Interface
REQ-001 Parameters SHALL be DATA_W, default 32, io data width.
REQ-002 Parameters SHALL include ADDR_W, default 32, io address width.
REQ-003 Parameters SHALL include NUM_CH, default 4, peripheral channel count (1..16, not necessarily a power of 2).
REQ-004 Parameters SHALL include CH_SEL_LSB, default 12, lowest address bit of the channel selector field; selector width CH_W = clog2(NUM_CH), minimum 1.
REQ-005 Parameters SHALL include TIMEOUT_CYC, default 16, wait-cycle limit (used only with IO_TIMEOUT_EN).
REQ-006 Ports SHALL be: clk  in  1  sole clock, rising edge; rst_n  in  1  reset, asynchronous, active-low.
REQ-007 io_address  in  ADDR_W  core access address; io_write_value  in  DATA_W  core write data; io_write_en  in  1  core write strobe; io_read_en  in  1  core read strobe.
REQ-008 io_read_value  out  DATA_W  read data to core; io_stall  out  1  core must hold state and io inputs while high.
REQ-009 ch_addr  out  ADDR_W  registered address; ch_wdata  out  DATA_W  registered write data; ch_we  out  1  registered write flag.
REQ-010 ch_req  out  NUM_CH  one-hot request; ch_ack  in  NUM_CH  per-channel acknowledge; ch_rdata  in  NUM_CH*DATA_W  channel i at bits [i*DATA_W +: DATA_W].
REQ-011 bus_err  out  1  one-cycle error pulse.

Function
REQ-012 FSM states SHALL be IDLE, WAIT, DONE.
REQ-013 IDLE: access = io_read_en XOR io_write_en; sel = io_address[CH_SEL_LSB +: CH_W]; mapped = sel < NUM_CH.
REQ-014 io_stall SHALL be combinational: high in IDLE when access and mapped, high throughout WAIT, low in DONE.
REQ-015 IDLE, access and mapped: at the edge, register address, write data, ch_we = io_write_en, set ch_req[sel], go to WAIT.
REQ-016 IDLE, access and unmapped: no request; io_read_value = 0 that cycle; bus_err = 1 next cycle; stay IDLE.
REQ-017 IDLE, both strobes high: treated as illegal; no request, no stall, bus_err = 1 next cycle.
REQ-018 WAIT: hold ch_req, ch_addr, ch_wdata, ch_we stable until ch_ack of the selected channel is high at an edge.
REQ-019 On that edge: clear ch_req, capture ch_rdata of selected channel (reads only) into read register, go to DONE.
REQ-020 ch_ack on non-selected channels SHALL be ignored.
REQ-021 DONE: io_read_value = captured data; strobes ignored; unconditional return to IDLE next edge.
REQ-022 Outside DONE and REQ-016, io_read_value SHALL be 0.
REQ-023 Latency: ack in first WAIT cycle gives 3 cycles strobe-to-completion (IDLE, WAIT, DONE); each extra wait cycle adds one.
REQ-024 At most one ch_req bit SHALL ever be high.

Reset
REQ-025 rst_n low SHALL immediately force IDLE, ch_req = 0, ch_we = 0, ch_addr = 0, ch_wdata = 0, read register = 0, bus_err = 0, timeout count = 0.
REQ-026 Reset mid-WAIT SHALL abandon the access with no completion or error; acks arriving after reset are ignored.

Configuration
REQ-027 Macro IO_TIMEOUT_EN SHALL, when defined, add a WAIT-cycle counter cleared on entry to WAIT.
REQ-028 With IO_TIMEOUT_EN: if TIMEOUT_CYC WAIT cycles elapse without ack, clear ch_req, go to DONE with io_read_value all-ones, and pulse bus_err for one cycle; ack on the expiry edge takes priority over timeout.
REQ-029 Without IO_TIMEOUT_EN: no counter logic; WAIT persists until ack.

Verification
REQ-030 Read ch2 at 0x0000_2010 with ack on first WAIT cycle and ch_rdata[2] = 0xDEAD_BEEF -> ch_req = 4'b0100 for 1 cycle; io_stall high 2 cycles; DONE io_read_value = 0xDEAD_BEEF.
REQ-031 Write 0x1234_5678 to ch1 at 0x0000_1004 with ack after 5 wait cycles -> ch_we = 1, ch_wdata stable 0x1234_5678 for 5 cycles; 7 cycles total; bus_err 0.
REQ-032 NUM_CH = 3, read 0x0000_3000 -> no ch_req, io_stall 0, io_read_value 0, bus_err pulse next cycle.
REQ-033 IO_TIMEOUT_EN, TIMEOUT_CYC = 16, ch0 never acks -> ch_req drops after 16 WAIT cycles; io_read_value 0xFFFF_FFFF in DONE; bus_err one pulse.
REQ-034 rst_n low on third WAIT cycle -> ch_req and io_stall 0 immediately; late ack ignored; next read completes normally.
REQ-035 Both strobes high, and ch3 ack while ch0 selected -> bus_err pulse / no completion respectively; only ch0 ack completes.
